// File: rtl/rvfi_serializer.sv
`default_nettype none
// ============================================================================
// Module      : rvfi_serializer
// Description : Collects up to NRET retire records per cycle into a FIFO and
//               presents them one at a time in lane order. A group is
//               accepted whole or dropped whole. Drops are counted with a
//               saturating counter.
//               Optional build macro RVFI_SER_ORDER_CHECK_EN adds a check
//               that consecutive popped records have orders that step by 1.
// Revision    : 1.0 - initial release
// ============================================================================
module rvfi_serializer #(
  parameter int NRET   = 2,
  parameter int REC_W  = 512,
  parameter int DEPTH  = 8,
  parameter int DROP_W = 16
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic                                     flush_i,
  input  logic [NRET-1:0]                          in_valid_i,
  input  logic [NRET*REC_W-1:0]                    in_rec_i,
  output logic                                     out_valid_o,
  input  logic                                     out_ready_i,
  output logic [REC_W-1:0]                         out_rec_o,
  output logic [((NRET > 1) ? $clog2(NRET) : 1)-1:0] out_lane_o,
  output logic [$clog2(DEPTH):0]                   level_o,
  output logic                                     overflow_o,
  output logic [DROP_W-1:0]                        drop_cnt_o,
  output logic                                     order_err_o
);

  localparam int PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW     = $clog2(DEPTH) + 1;
  localparam int LANE_W = (NRET > 1) ? $clog2(NRET) : 1;
  localparam int SW     = ((DROP_W > LW) ? DROP_W : LW) + 1;
  localparam logic [PW-1:0] PTR_MASK = PW'(DEPTH - 1);

  // Storage has no reset: occupancy and pointers alone decide what is valid.
  logic [REC_W-1:0]  mem_rec_q  [DEPTH];
  logic [LANE_W-1:0] mem_lane_q [DEPTH];

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  logic [LW-1:0]     n_w;
  logic [PW-1:0]     idx_w [NRET];
  logic [LW:0]       free_w;
  logic              pop_w;
  logic              push_ok_w;
  logic              drop_w;
  logic [SW-1:0]     drop_sum_w;

  assign out_valid_o = (level_q != '0);
  assign out_rec_o   = mem_rec_q[rd_ptr_q];
  assign out_lane_o  = mem_lane_q[rd_ptr_q];
  assign level_o     = level_q;
  assign overflow_o  = overflow_q;
  assign drop_cnt_o  = drop_cnt_q;

  assign pop_w      = out_valid_o & out_ready_i;
  // A pop this cycle frees a slot for this cycle's group.
  assign free_w     = (LW + 1)'(DEPTH) - {1'b0, level_q} + (LW + 1)'(pop_w);
  assign push_ok_w  = !flush_i && (n_w != '0) && ({1'b0, n_w} <= free_w);
  assign drop_w     = !flush_i && (n_w != '0) && ({1'b0, n_w} >  free_w);
  assign drop_sum_w = SW'(drop_cnt_q) + SW'(n_w);

  // Compact valid lanes: each valid lane lands at write pointer + count of older valid lanes.
  always_comb begin
    n_w = '0;
    for (int k = 0; k < NRET; k++) begin
      idx_w[k] = (wr_ptr_q + PW'(n_w)) & PTR_MASK;
      n_w      = n_w + LW'(in_valid_i[k]);
    end
  end

  // Write accepted lanes into consecutive FIFO slots.
  always_ff @(posedge clk_i) begin
    if (push_ok_w) begin
      for (int k = 0; k < NRET; k++) begin
        if (in_valid_i[k]) begin
          mem_rec_q[idx_w[k]]  <= in_rec_i[k*REC_W +: REC_W];
          mem_lane_q[idx_w[k]] <= LANE_W'(k);
        end
      end
    end
  end

  // Next-state for pointers, occupancy and drop bookkeeping.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (push_ok_w) begin
      wr_ptr_d = (wr_ptr_q + PW'(n_w)) & PTR_MASK;
    end
    if (pop_w) begin
      rd_ptr_d = (rd_ptr_q + PW'(1)) & PTR_MASK;
    end
    level_d = level_q + (push_ok_w ? n_w : LW'(0)) - LW'(pop_w);
    if (drop_w) begin
      overflow_d = 1'b1;
      drop_cnt_d = (|drop_sum_w[SW-1:DROP_W]) ? {DROP_W{1'b1}} : drop_sum_w[DROP_W-1:0];
    end
  end

  // State register; flush overrides any push or pop in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else if (flush_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

`ifdef RVFI_SER_ORDER_CHECK_EN
  logic [63:0] prev_order_q;
  logic        have_prev_q;
  logic        order_err_q;
  logic [63:0] head_order_w;

  assign head_order_w = out_rec_o[63:0];
  assign order_err_o  = order_err_q;

  // Track the last popped order; the first pop after reset/flush only seeds it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_order_q <= '0;
      have_prev_q  <= 1'b0;
      order_err_q  <= 1'b0;
    end else if (flush_i) begin
      prev_order_q <= '0;
      have_prev_q  <= 1'b0;
      order_err_q  <= 1'b0;
    end else if (pop_w) begin
      prev_order_q <= head_order_w;
      have_prev_q  <= 1'b1;
      if (have_prev_q && (head_order_w != prev_order_q + 64'd1)) begin
        order_err_q <= 1'b1;
      end
    end
  end
`else
  assign order_err_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rvfi_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rvfi_serializer
// Description : Directed self-checking bench for rvfi_serializer with
//               NRET=2, REC_W=512, DEPTH=8, DROP_W=16.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rvfi_serializer;

  localparam int NRET   = 2;
  localparam int REC_W  = 512;
  localparam int DEPTH  = 8;
  localparam int DROP_W = 16;
`ifdef RVFI_SER_ORDER_CHECK_EN
  localparam logic ORD_EN = 1'b1;
`else
  localparam logic ORD_EN = 1'b0;
`endif

  logic                    clk_i = 1'b0;
  logic                    rst_ni;
  logic                    flush_i;
  logic [NRET-1:0]         in_valid_i;
  logic [NRET*REC_W-1:0]   in_rec_i;
  logic                    out_valid_o;
  logic                    out_ready_i;
  logic [REC_W-1:0]        out_rec_o;
  logic [0:0]              out_lane_o;
  logic [3:0]              level_o;
  logic                    overflow_o;
  logic [DROP_W-1:0]       drop_cnt_o;
  logic                    order_err_o;

  int checks   = 0;
  int failures = 0;

  rvfi_serializer #(
    .NRET  (NRET),
    .REC_W (REC_W),
    .DEPTH (DEPTH),
    .DROP_W(DROP_W)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .flush_i    (flush_i),
    .in_valid_i (in_valid_i),
    .in_rec_i   (in_rec_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_rec_o  (out_rec_o),
    .out_lane_o (out_lane_o),
    .level_o    (level_o),
    .overflow_o (overflow_o),
    .drop_cnt_o (drop_cnt_o),
    .order_err_o(order_err_o)
  );

  always #5 clk_i = ~clk_i;

  // Record with order in [63:0] and order-derived patterns elsewhere.
  function automatic logic [REC_W-1:0] mkrec(input logic [63:0] ord);
    logic [REC_W-1:0] r;
    r            = '0;
    r[63:0]      = ord;
    r[255:192]   = ~ord;
    r[511:448]   = ord ^ 64'hC3C3_5A5A_0F0F_F00F;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [63:0] o0, input logic [63:0] o1);
    in_valid_i = v;
    in_rec_i   = {mkrec(o1), mkrec(o0)};
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [63:0] ord, input logic lane);
    checks++;
    assert (out_rec_o === mkrec(ord)) else begin
      failures++;
      $error("FAIL %s_rec observed_order=%0h expected_order=%0h", tag, out_rec_o[63:0], ord);
    end
    chk({tag, "_lane"}, 64'(out_lane_o), 64'(lane));
    chk({tag, "_valid"}, 64'(out_valid_o), 64'd1);
  endtask

  initial begin
    rst_ni      = 1'b0;
    flush_i     = 1'b0;
    out_ready_i = 1'b0;
    drive(2'b00, 64'd0, 64'd0);
    tick();
    tick();
    chk("rst_level",    64'(level_o),     64'd0);
    chk("rst_valid",    64'(out_valid_o), 64'd0);
    chk("rst_overflow", 64'(overflow_o),  64'd0);
    chk("rst_drop",     64'(drop_cnt_o),  64'd0);
    chk("rst_ordererr", 64'(order_err_o), 64'd0);
    rst_ni = 1'b1;
    tick();

    // Two lanes, orders 5 and 6, sink always ready.
    out_ready_i = 1'b1;
    drive(2'b11, 64'd5, 64'd6);
    tick();
    drive(2'b00, 64'd0, 64'd0);
    chk_head("pair_first", 64'd5, 1'b0);
    chk("pair_level1", 64'(level_o), 64'd2);
    tick();
    chk_head("pair_second", 64'd6, 1'b1);
    chk("pair_level2", 64'(level_o), 64'd1);
    tick();
    chk("pair_empty", 64'(out_valid_o), 64'd0);

    // Only lane 1 valid; invalid lane 0 must be skipped.
    out_ready_i = 1'b0;
    drive(2'b10, 64'd100, 64'd9);
    tick();
    drive(2'b00, 64'd0, 64'd0);
    chk_head("lane1_only", 64'd9, 1'b1);
    chk("lane1_level", 64'(level_o), 64'd1);
    tick();
    chk_head("lane1_hold", 64'd9, 1'b1);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("flush1_level", 64'(level_o), 64'd0);
    chk("flush1_valid", 64'(out_valid_o), 64'd0);

    // Fill to 7 with sink stalled, then a 2-lane group must be dropped.
    drive(2'b11, 64'd10, 64'd11); tick();
    drive(2'b11, 64'd12, 64'd13); tick();
    drive(2'b11, 64'd14, 64'd15); tick();
    drive(2'b01, 64'd16, 64'd0);  tick();
    chk("fill7_level", 64'(level_o), 64'd7);
    chk("fill7_overflow", 64'(overflow_o), 64'd0);
    drive(2'b11, 64'd90, 64'd91);
    tick();
    drive(2'b00, 64'd0, 64'd0);
    chk("drop_level", 64'(level_o), 64'd7);
    chk("drop_overflow", 64'(overflow_o), 64'd1);
    chk("drop_cnt", 64'(drop_cnt_o), 64'd2);
    chk_head("drop_head", 64'd10, 1'b0);

    // Level 7: pop plus 1-lane push in the same cycle is accepted.
    out_ready_i = 1'b1;
    drive(2'b01, 64'd17, 64'd0);
    tick();
    drive(2'b00, 64'd0, 64'd0);
    chk("poppush_level", 64'(level_o), 64'd7);
    chk("poppush_drop", 64'(drop_cnt_o), 64'd2);
    chk_head("poppush_head", 64'd11, 1'b1);

    // Drain across the pointer wrap: orders 11..17.
    for (int i = 0; i < 7; i++) begin
      chk("drain_order", out_rec_o[63:0], 64'(11 + i));
      tick();
    end
    chk("drain_level", 64'(level_o), 64'd0);
    chk("drain_ordererr", 64'(order_err_o), 64'd0);

    // Flush clears sticky drop state and order history.
    out_ready_i = 1'b0;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("flush2_drop", 64'(drop_cnt_o), 64'd0);
    chk("flush2_overflow", 64'(overflow_o), 64'd0);

    // Order sequence 3, 4, 6.
    drive(2'b11, 64'd3, 64'd4); tick();
    drive(2'b01, 64'd6, 64'd0); tick();
    drive(2'b00, 64'd0, 64'd0);
    chk("ord_level", 64'(level_o), 64'd3);
    out_ready_i = 1'b1;
    tick();
    tick();
    chk_head("ord_head6", 64'd6, 1'b0);
    chk("ord_err_before", 64'(order_err_o), 64'd0);
    tick();
    out_ready_i = 1'b0;
    chk("ord_err_after", 64'(order_err_o), 64'(ORD_EN));
    chk("ord_level_end", 64'(level_o), 64'd0);

    // Flush together with a 2-lane push at level 4.
    drive(2'b11, 64'd30, 64'd31); tick();
    drive(2'b11, 64'd32, 64'd33); tick();
    chk("fl4_level_pre", 64'(level_o), 64'd4);
    drive(2'b11, 64'd34, 64'd35);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    drive(2'b00, 64'd0, 64'd0);
    chk("fl4_level", 64'(level_o), 64'd0);
    chk("fl4_drop", 64'(drop_cnt_o), 64'd0);
    chk("fl4_valid", 64'(out_valid_o), 64'd0);
    chk("fl4_ordererr", 64'(order_err_o), 64'd0);
    tick();
    chk("fl4_valid_after", 64'(out_valid_o), 64'd0);

    // Fill to full, overflow, then asynchronous reset mid-stream.
    drive(2'b11, 64'd20, 64'd21); tick();
    drive(2'b11, 64'd22, 64'd23); tick();
    drive(2'b11, 64'd24, 64'd25); tick();
    drive(2'b11, 64'd26, 64'd27); tick();
    chk("full_level", 64'(level_o), 64'd8);
    chk_head("full_head", 64'd20, 1'b0);
    drive(2'b11, 64'd28, 64'd29); tick();
    drive(2'b00, 64'd0, 64'd0);
    chk("full_drop", 64'(drop_cnt_o), 64'd2);
    chk("full_overflow", 64'(overflow_o), 64'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_level",    64'(level_o),     64'd0);
    chk("arst_valid",    64'(out_valid_o), 64'd0);
    chk("arst_overflow", 64'(overflow_o),  64'd0);
    chk("arst_drop",     64'(drop_cnt_o),  64'd0);
    chk("arst_ordererr", 64'(order_err_o), 64'd0);
    tick();
    rst_ni = 1'b1;
    out_ready_i = 1'b1;
    tick();
    tick();
    chk("post_rst_valid", 64'(out_valid_o), 64'd0);
    chk("post_rst_level", 64'(level_o), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rvfi_serializer.md
RVFI_SERIALIZER -- requirements
Module: rvfi_serializer

Interface
REQ-001 SHALL have parameter NRET, default 2: number of retire lanes, 1..8.
REQ-002 SHALL have parameter REC_W, default 512: bits per flattened retire record; bits [63:0] hold the order field.
REQ-003 SHALL have parameter DEPTH, default 8: FIFO entries, a power of two, at least NRET.
REQ-004 SHALL have parameter DROP_W, default 16: width of the drop counter.
REQ-005 SHALL have port clk_i, input, 1: single clock, all state on its rising edge.
REQ-006 SHALL have port rst_ni, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port flush_i, input, 1: synchronous flush.
REQ-008 SHALL have port in_valid_i, input, NRET: per-lane retire valid; lane 0 is oldest.
REQ-009 SHALL have port in_rec_i, input, NRET*REC_W: lane k occupies bits [k*REC_W +: REC_W].
REQ-010 SHALL have port out_valid_o, output, 1: head record available.
REQ-011 SHALL have port out_ready_i, input, 1: sink accepts the head record.
REQ-012 SHALL have port out_rec_o, output, REC_W: head record.
REQ-013 SHALL have port out_lane_o, output, max(1,$clog2(NRET)): source lane of the head record.
REQ-014 SHALL have port level_o, output, $clog2(DEPTH)+1: current occupancy.
REQ-015 SHALL have port overflow_o, output, 1: sticky drop flag.
REQ-016 SHALL have port drop_cnt_o, output, DROP_W: count of dropped records, saturating.
REQ-017 SHALL have port order_err_o, output, 1: sticky order-discontinuity flag.

Function
REQ-018 SHALL define pop = out_valid_o AND out_ready_i; popping advances the read pointer by one.
REQ-019 SHALL define n = popcount(in_valid_i) and free = DEPTH - level_o + pop.
REQ-020 SHALL, when n > 0 and n <= free, write all valid lanes in ascending lane index to consecutive FIFO entries in one cycle; invalid lanes are skipped without leaving gaps.
REQ-021 SHALL, when n > free, drop the whole group (all-or-nothing), set overflow_o, and add n to drop_cnt_o, saturating at all-ones.
REQ-022 SHALL handle push and pop in the same cycle: level_o(next) = level_o + pushed count - pop.
REQ-023 SHALL drive out_valid_o = (level_o != 0), with out_rec_o and out_lane_o taken from the head entry; both are stable while out_valid_o is high and out_ready_i is low.
REQ-024 SHALL have a latency of one cycle: a record written in cycle N is first visible at the output in cycle N+1, with no bypass path.
REQ-025 SHALL wrap read and write pointers modulo DEPTH; the full condition is level_o == DEPTH.
REQ-026 SHALL give flush_i priority over everything else: it empties the FIFO and clears overflow_o, drop_cnt_o, order_err_o and the order history; a push or pop in the same cycle is discarded and not counted as a drop.
REQ-027 SHALL leave out_rec_o and out_lane_o as don't-care while out_valid_o is low.

Reset
REQ-028 SHALL, while rst_ni is low, asynchronously force: pointers 0, level_o 0, out_valid_o 0, overflow_o 0, drop_cnt_o 0, order_err_o 0, order history empty.
REQ-029 SHALL discard all FIFO contents when reset is asserted mid-stream; no stale record appears after reset is released.
REQ-030 SHALL release reset synchronously to clk_i; this release synchronisation is external to the block.

Configuration
REQ-031 SHALL, with RVFI_SER_ORDER_CHECK_EN defined, compare order[63:0] of each popped record against the previously popped order plus 1 (modulo 2^64); the first pop after reset or flush is unchecked.
REQ-032 SHALL, on a mismatch in that check, set order_err_o, hold it until reset or flush, and keep the popped order as the new reference.
REQ-033 SHALL, with RVFI_SER_ORDER_CHECK_EN undefined, tie order_err_o to 0 and synthesise no order-check storage.

Verification
REQ-034 SHALL cover: NRET=2, lanes 0 and 1 valid with orders 5 and 6, out_ready_i=1 -> out_rec_o orders 5 then 6 in cycles N+1 and N+2, with out_lane_o 0 then 1.
REQ-035 SHALL cover: only lane 1 valid with order 9 -> one entry, out_lane_o=1, level_o=1.
REQ-036 SHALL cover: out_ready_i=0 with DEPTH=8 filled to 7, then both lanes valid -> group dropped, overflow_o=1, drop_cnt_o=2, level_o stays 7.
REQ-037 SHALL cover: level_o=7 and a pop in the same cycle as a 1-lane push -> accepted, level_o stays 7, no drop.
REQ-038 SHALL cover: with the macro defined, popped orders 3, 4, 6 -> order_err_o rises in the cycle after the pop of 6; without the macro order_err_o stays 0.
REQ-039 SHALL cover: flush_i and a 2-lane push in the same cycle at level_o=4 -> level_o=0, drop_cnt_o=0, out_valid_o=0 the next cycle; rst_ni low mid-stream -> all outputs at reset values immediately.
